// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: one-hot op codes, FSM state type
// and the op legality helper.
package alu_arb_pkg;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_SLT = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Legal ops have exactly one bit set.
  function automatic logic is_legal_op(input logic [4:0] op);
    return (op != 5'd0) && ((op & (op - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above rr_ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NREQ)) begin
        idx = idx - (IDX_W+1)'(NREQ);
      end
      sel = idx[IDX_W-1:0];
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ requesters.
// Optional ALU_ARB_ILLEGAL_OP_EN: illegal ops are neutralised and flagged on rsp_err.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [5*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_zero,
`ifdef ALU_ARB_ILLEGAL_OP_EN
  output logic                  rsp_err,
`endif
  output logic [4:0]            alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_zero
);

  localparam int IDX_W = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, owner, grant_idx;
  logic [NREQ-1:0]  grant;
  logic [4:0]       op_q, win_op;
  logic [WIDTH-1:0] a_q, b_q, win_a, win_b;
  logic             accept, done;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic             err_q;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign win_op = req_op[int'(grant_idx)*5 +: 5];
  assign win_a  = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign win_b  = req_b[int'(grant_idx)*WIDTH +: WIDTH];

  assign accept = (state == IDLE) && (|req_valid);
  assign done   = (state == RESP) && rsp_ready[owner];

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operand capture on grant; p1: result capture after the ALU cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_q    <= 1'b0;
      rsp_err  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        owner <= grant_idx;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (is_legal_op(win_op)) begin
          op_q  <= win_op;
          a_q   <= win_a;
          b_q   <= win_b;
          err_q <= 1'b0;
        end else begin
          op_q  <= OP_ADD;
          a_q   <= '0;
          b_q   <= '0;
          err_q <= 1'b1;
        end
`else
        op_q <= win_op;
        a_q  <= win_a;
        b_q  <= win_b;
`endif
      end
      if (state == EXEC) begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
        rsp_data <= err_q ? '0 : alu_out;
        rsp_zero <= err_q ? 1'b1 : alu_zero;
        rsp_err  <= err_q;
`else
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
`endif
      end
      if (done) begin
        rr_ptr <= (owner == IDX_W'(NREQ-1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level reference
// model (round-robin order, T+2 latency, arithmetic results).
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a, req_b;
  logic [W-1:0]    rsp_data, alu_a, alu_b, alu_out;
  logic            rsp_zero, alu_zero;
  logic [4:0]      alu_op;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic            rsp_err;
`endif

  alu_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
`ifdef ALU_ARB_ILLEGAL_OP_EN
    .rsp_err   (rsp_err),
`endif
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    case (alu_op)
      5'b00001: alu_out = alu_a + alu_b;
      5'b00010: alu_out = alu_a - alu_b;
      5'b00100: alu_out = alu_a & alu_b;
      5'b01000: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      5'b10000: alu_out = alu_a | alu_b;
      default:  alu_out = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_a == alu_b);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result from the op definitions, using plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned sa, sb, r;
    sa = longint'(a);
    sb = longint'(b);
    r  = 0;
    if (op == 5'b00001) r = (sa + sb) % (64'd1 << W);
    if (op == 5'b00010) r = (sa + (64'd1 << W) - sb) % (64'd1 << W);
    if (op == 5'b00100) r = sa & sb;
    if (op == 5'b01000) r = (sa < sb) ? 1 : 0;
    if (op == 5'b10000) r = sa | sb;
    return r[W-1:0];
  endfunction

  // Requester intentions
  bit         pend_v [NREQ];
  logic [4:0] pend_op[NREQ];
  logic [W-1:0] pend_a[NREQ], pend_b[NREQ];
  bit gen_en, sticky, rdy_rand;
  int stall;

  // Model of the outstanding transaction
  bit busy;
  int owner, acc_cyc, ptr, cyc;
  logic [W-1:0] exp_data;
  bit exp_zero, exp_err;
  int grant_log[$];

  logic [4:0] legal_ops[5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

  task automatic set_req(input int i, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    pend_v[i] = 1'b1; pend_op[i] = op; pend_a[i] = a; pend_b[i] = b;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
  endtask

  task automatic model_cycle();
    int w;
    int idx;
    logic [NREQ-1:0] er, ev;
    w = -1; er = '0; ev = '0;
    if (!busy) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr + k) % NREQ;
        if (w < 0 && pend_v[idx]) w = idx;
      end
      if (w >= 0) er[w] = 1'b1;
    end else if (cyc >= acc_cyc + 2) begin
      ev[owner] = 1'b1;
    end
    check("req_ready", req_ready, er);
    check("rsp_valid", rsp_valid, ev);
    if (ev != '0) begin
      check("rsp_data", rsp_data, exp_data);
      check("rsp_zero", rsp_zero, exp_zero);
`ifdef ALU_ARB_ILLEGAL_OP_EN
      check("rsp_err", rsp_err, exp_err);
`endif
    end
    if (!busy && w >= 0) begin
      busy = 1'b1; owner = w; acc_cyc = cyc;
      grant_log.push_back(w);
      exp_err  = ($countones(pend_op[w]) != 1);
      exp_data = exp_err ? '0 : ref_result(pend_op[w], pend_a[w], pend_b[w]);
      exp_zero = exp_err ? 1'b1 : (pend_a[w] == pend_b[w]);
      if (!sticky) pend_v[w] = 1'b0;
    end else if (busy && cyc >= acc_cyc + 2) begin
      if (rsp_ready[owner]) begin
        busy = 1'b0;
        ptr  = (owner + 1) % NREQ;
      end else if (stall > 0) begin
        stall--;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (gen_en && !pend_v[i] && $urandom_range(0, 2) == 0) begin
        pend_v[i]  = 1'b1;
        pend_op[i] = legal_ops[$urandom_range(0, 4)];
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if ($urandom_range(0, 7) == 0) pend_op[i] = 5'($urandom_range(0, 31));
`endif
        pend_a[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
        pend_b[i] = ($urandom_range(0, 3) == 0) ? pend_a[i] : W'($urandom);
      end else if (gen_en && pend_v[i] && $urandom_range(0, 15) == 0) begin
        pend_v[i] = 1'b0;
      end
      req_valid[i]        = pend_v[i];
      req_op[i*5 +: 5]    = pend_op[i];
      req_a[i*W +: W]     = pend_a[i];
      req_b[i*W +: W]     = pend_b[i];
    end
    rsp_ready = rdy_rand ? NREQ'($urandom) : '1;
    if (stall > 0 && busy) begin
      rsp_ready        = '1;
      rsp_ready[owner] = 1'b0;
    end
    #1;
    model_cycle();
    cyc++;
  endtask

  task automatic drain();
    clear_reqs();
    gen_en = 1'b0; sticky = 1'b0; rdy_rand = 1'b0; stall = 0;
    repeat (6) step();
  endtask

  initial begin
    int p0;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0; pend_op[i] = 5'b00001; pend_a[i] = '0; pend_b[i] = '0;
    end
    gen_en = 0; sticky = 0; rdy_rand = 0; stall = 0;
    busy = 0; owner = 0; acc_cyc = 0; ptr = 0; cyc = 0;
    exp_data = '0; exp_zero = 0; exp_err = 0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_alu_op", alu_op, 5'b00001);
    check("rst_alu_a", alu_a, '0);
    check("rst_alu_b", alu_b, '0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    check("rst_rsp_err", rsp_err, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single ADD 5+7 from requester 0
    grant_log.delete();
    set_req(0, 5'b00001, 32'd5, 32'd7);
    step();
    check("single_grant", grant_log[0], 0);
    step();
    step();
    check("single_data", rsp_data, 32'd12);
    check("single_zero", rsp_zero, 1'b0);
    drain();

    // Both requesters continuously valid: grants alternate
    grant_log.delete();
    p0 = ptr;
    sticky = 1'b1;
    set_req(0, 5'b00010, 32'd9, 32'd9);
    set_req(1, 5'b01000, 32'd3, 32'd8);
    repeat (14) step();
    drain();
    check("alt_count", grant_log.size() >= 4, 1'b1);
    for (int i = 0; i < grant_log.size(); i++) check("alt_order", grant_log[i], (p0 + i) % NREQ);

    // Backpressure on requester 1 while requester 0 waits
    set_req(1, 5'b00100, 32'hF0F0_1234, 32'h0FF0_FFFF);
    step();
    set_req(0, 5'b00001, 32'd1, 32'd1);
    stall = 5;
    repeat (10) step();
    drain();

    // Wrap and width
    set_req(0, 5'b00001, 32'hFFFF_FFFF, 32'd1);
    repeat (4) step();
    set_req(1, 5'b10000, 32'hF0F0_0000, 32'h0000_0F0F);
    repeat (4) step();
    drain();

    // Randomised traffic with random response backpressure
    gen_en = 1'b1; rdy_rand = 1'b1;
    repeat (400) step();
    drain();

    // Reset while a transaction is in EXEC
    set_req(0, 5'b00001, 32'd1, 32'd2);
    repeat (4) step();
    check("pre_rst_ptr", ptr, 1);
    set_req(1, 5'b00010, 32'd50, 32'd8);
    step();
    @(negedge clk);
    clear_reqs();
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_req_ready", req_ready, '0);
    check("mid_rst_rsp_valid", rsp_valid, '0);
    check("mid_rst_rsp_data", rsp_data, '0);
    check("mid_rst_rsp_zero", rsp_zero, 1'b0);
    check("mid_rst_alu_a", alu_a, '0);
    check("mid_rst_alu_op", alu_op, 5'b00001);
    @(negedge clk);
    rst = 1'b0;
    busy = 1'b0; ptr = 0;
    repeat (3) step();
    grant_log.delete();
    set_req(0, 5'b00100, 32'hFF, 32'h0F);
    set_req(1, 5'b00001, 32'd2, 32'd3);
    step();
    check("post_rst_grant", grant_log[0], 0);
    repeat (8) step();
    drain();

`ifdef ALU_ARB_ILLEGAL_OP_EN
    // Illegal op is neutralised and flagged
    set_req(0, 5'b00011, 32'h1234, 32'h99);
    repeat (3) step();
    check("illegal_err", rsp_err, 1'b1);
    check("illegal_data", rsp_data, '0);
    check("illegal_zero", rsp_zero, 1'b1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (one-hot 5-bit op, 32-bit A/B, out, zero) between NREQ requesters, e.g. an execute-stage client and a multicycle/debug client.
- Per-requester valid/ready request channel and valid/ready response channel.
- Round-robin arbitration; one transaction in flight at a time.
- Operands are registered before they reach the ALU, and the result is registered after it.

Parameters:
- NREQ, 2, number of requesters (2..4)
- WIDTH, 32, operand/result width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  request accepted; one-hot, single-cycle pulse
- req_op  in  5*NREQ  one-hot op per requester (packed, requester i at [5i+4:5i])
- req_a  in  WIDTH*NREQ  operand A per requester
- req_b  in  WIDTH*NREQ  operand B per requester
- rsp_valid  out  NREQ  result valid for owning requester; one-hot
- rsp_ready  in  NREQ  requester consumes result
- rsp_data  out  WIDTH  result (shared bus, qualified by rsp_valid)
- rsp_zero  out  1  captured ALU zero flag (A==B)
- alu_op  out  5  to ALU op input
- alu_a  out  WIDTH  to ALU A input
- alu_b  out  WIDTH  to ALU B input
- alu_out  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero

Behaviour:
- Op encoding: ADD=00001, SUB=00010, AND=00100, SLT=01000, OR=10000. Anything else is illegal.
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, owner=0, op_q=00001, a_q=b_q=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0.
- ALU drive: alu_op/alu_a/alu_b = op_q/a_q/b_q at all times (registered, glitch-free into the ALU).
- IDLE:
  - If any req_valid: winner = first requester with valid, searching from rr_ptr upward with wrap.
  - Assert req_ready[winner] combinationally this cycle.
  - Latch op_q/a_q/b_q from the winner's slice and owner=winner; next state EXEC.
  - Otherwise stay in IDLE; the op/a/b registers hold.
- EXEC (one cycle):
  - ALU computes from the registers.
  - At cycle end: rsp_data<=alu_out, rsp_zero<=alu_zero; next state RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_data/rsp_zero held stable.
  - When rsp_ready[owner]=1: rsp_valid drops next cycle, rr_ptr<=(owner+1) mod NREQ, next state IDLE.
  - rsp_ready of non-owners is ignored.
- Latency and throughput:
  - Request accepted at cycle T: rsp_valid high from T+2.
  - Best case one transaction per 3 cycles (RESP consumed immediately).
- req_valid is sampled only in IDLE:
  - A requester may drop valid before it is accepted without any effect.
  - Losing requesters see req_ready=0 and must hold their request.
- Fairness: a requester continuously asserting valid is granted within NREQ transactions.
- Width rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is an unsigned compare producing 0 or 1, zero-extended.
  - rsp_zero reflects A==B regardless of op.
- Reset mid-operation: the transaction is dropped silently, no response is produced, and arbitration restarts at requester 0.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_OP_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0, valid with rsp_valid).
  - On an illegal req_op: op_q is loaded with ADD and a_q=b_q=0.
  - The response is rsp_data=0, rsp_zero=1, rsp_err=1.
  - Timing is the same as for a legal op.
- Undefined:
  - No rsp_err port.
  - The op is forwarded unchanged.
  - rsp_data is whatever alu_out presents; the bench must not check it.

Decomposition:
- Package alu_arb_pkg:
  - op constants OP_ADD/OP_SUB/OP_AND/OP_SLT/OP_OR.
  - state typedef (IDLE/EXEC/RESP).
  - function is_legal_op (exactly one bit set).
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and grant index.

Test Plan:
- Single request: req0 ADD A=5 B=7 at T -> req_ready[0] at T, rsp_valid[0] at T+2, rsp_data=12, rsp_zero=0.
- Both valid continuously, requester 0 SUB 9-9, requester 1 SLT 3<8 -> grants alternate 0,1,0,1; req0 rsp_data=0 with rsp_zero=1; req1 rsp_data=1.
- Backpressure: rsp_ready[1]=0 for 5 cycles in RESP -> rsp_valid[1] and rsp_data held stable; no new req_ready during the stall; rsp_ready[0] ignored.
- Wrap and width: ADD 0xFFFFFFFF+1 -> rsp_data=0, rsp_zero=0; OR 0xF0F0_0000|0x0000_0F0F -> 0xF0F0_0F0F.
- Reset asserted during EXEC -> all outputs 0 immediately; no rsp_valid afterwards; next grant goes to requester 0.
- With ALU_ARB_ILLEGAL_OP_EN: op=00011 -> rsp_err=1, rsp_data=0, rsp_zero=1 at T+2.
